// File: rtl/pe_conv_pkg.sv
// Shared constants and types for the convolution PE scheduler: stage depths,
// activation modes and the scheduler state encoding.
package pe_conv_pkg;

    localparam int MAC_STAGES_DEFAULT = 7;
    localparam int DEQUANT_STAGES     = 1;
    localparam int BIAS_STAGES        = 1;
    localparam int QUANT_STAGES       = 1;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_RELU,
        ACT_SIGMOID
    } act_mode_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } sched_state_t;

    // Adder tree reduces pINPUT_PARALLEL products, plus one output register.
    function automatic int adder_stages(input int input_parallel);
        return $clog2(input_parallel) + 1;
    endfunction

    function automatic int act_stages(input act_mode_t mode);
        return (mode == ACT_NONE) ? 0 : 1;
    endfunction

endpackage

// File: rtl/pe_stage_token_pipe.sv
// Freezable token shift register; taps[i] is a token launched i+1 unfrozen
// cycles ago and drives the matching datapath stage enable.
module pe_stage_token_pipe #(
    parameter int DEPTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             token_in,
    output logic [DEPTH-1:0] taps
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps <= '0;
        end else if (!freeze) begin
            taps <= {taps[DEPTH-2:0], token_in};
        end
    end

endmodule

// File: rtl/pe_conv_mac_sched.sv
// Convolution PE issue/pipeline scheduler. Optional performance counters are
// enabled by defining PE_CONV_MAC_SCHED_PERF_EN.
module pe_conv_mac_sched
    import pe_conv_pkg::*;
#(
    parameter int    pIN_CHANNEL      = 4,
    parameter int    pINPUT_PARALLEL  = 2,
    parameter int    pOUT_CHANNEL     = 32,
    parameter int    pOUTPUT_PARALLEL = 32,
    parameter int    pKERNEL_SIZE     = 3,
    parameter int    pMAC_STAGES      = MAC_STAGES_DEFAULT,
    parameter string pACTIVATION      = "relu",
    parameter int    pBIAS_NUM        = 32,
    localparam int   KK     = pKERNEL_SIZE * pKERNEL_SIZE,
    localparam int   IG     = pIN_CHANNEL / pINPUT_PARALLEL,
    localparam int   OG     = pOUT_CHANNEL / pOUTPUT_PARALLEL,
    localparam int   NISSUE = OG * IG * KK,
    localparam int   PW     = (KK > 1) ? $clog2(KK) : 1,
    localparam int   IW     = $clog2(IG) + 1,
    localparam int   OW     = $clog2(OG) + 1,
    localparam int   AW     = (NISSUE > 1) ? $clog2(NISSUE) : 1,
    localparam int   BW     = (pBIAS_NUM > 1) ? $clog2(pBIAS_NUM) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          win_valid,
    output logic          win_ready,
    input  logic          stall,
    input  logic          out_ready,
    output logic [PW-1:0] pixel,
    output logic [IW-1:0] ic_group,
    output logic [OW-1:0] oc_group,
    output logic [AW-1:0] kernel_addr,
    output logic [BW-1:0] bias_addr,
    output logic          acc_clr,
    output logic          adder_en,
    output logic          dequant_en,
    output logic          bias_en,
    output logic          act_en,
    output logic          quant_en,
    output logic          buffer_en,
    output logic [OW-1:0] buffer_idx,
    output logic          valid,
`ifdef PE_CONV_MAC_SCHED_PERF_EN
    output logic [31:0]   perf_issue_cnt,
    output logic [31:0]   perf_stall_cnt,
    output logic [31:0]   perf_bp_cnt,
`endif
    output logic          busy
);

    localparam act_mode_t ACT_MODE = (pACTIVATION == "none")    ? ACT_NONE :
                                     (pACTIVATION == "sigmoid") ? ACT_SIGMOID : ACT_RELU;
    localparam int C       = act_stages(ACT_MODE);
    localparam int T_ADD   = pMAC_STAGES;
    localparam int T_DEQ   = T_ADD + adder_stages(pINPUT_PARALLEL);
    localparam int T_BIAS  = T_DEQ + DEQUANT_STAGES;
    localparam int T_ACT   = T_BIAS + BIAS_STAGES;
    localparam int T_QUANT = T_ACT + C;
    localparam int T_BUF   = T_QUANT + QUANT_STAGES;

    sched_state_t     state, state_nxt;
    logic             freeze, issue_fire, token_in;
    logic             pix_last, ic_last, oc_last, last_issue;
    logic [T_BUF-1:0] taps;

    assign freeze     = stall || (valid && !out_ready);
    assign pix_last   = (pixel == PW'(KK - 1));
    assign ic_last    = (ic_group == IW'(IG - 1));
    assign oc_last    = (oc_group == OW'(OG - 1));
    assign last_issue = pix_last && ic_last && oc_last;
    assign issue_fire = (state == ISSUE) && !freeze;
    assign token_in   = issue_fire && pix_last && ic_last;
    assign acc_clr    = issue_fire && (pixel == '0) && (ic_group == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // An IDLE scheduler always takes a window, even while frozen; the first
    // issue then simply waits for the freeze to lift.
    always_comb begin
        state_nxt = state;
        win_ready = 1'b0;
        case (state)
            IDLE: begin
                win_ready = 1'b1;
                if (win_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (last_issue && !freeze) begin
                    win_ready = 1'b1;
                    if (!win_valid) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel       <= '0;
            ic_group    <= '0;
            oc_group    <= '0;
            kernel_addr <= '0;
        end else if (issue_fire) begin
            kernel_addr <= last_issue ? '0 : kernel_addr + 1'b1;
            if (!pix_last) begin
                pixel <= pixel + 1'b1;
            end else begin
                pixel <= '0;
                if (!ic_last) begin
                    ic_group <= ic_group + 1'b1;
                end else begin
                    ic_group <= '0;
                    oc_group <= oc_last ? '0 : oc_group + 1'b1;
                end
            end
        end
    end

    pe_stage_token_pipe #(
        .DEPTH (T_BUF)
    ) u_token_pipe (
        .clk      (clk),
        .rst      (rst),
        .freeze   (freeze),
        .token_in (token_in),
        .taps     (taps)
    );

    assign adder_en   = taps[T_ADD-1]   && !freeze;
    assign dequant_en = taps[T_DEQ-1]   && !freeze;
    assign bias_en    = taps[T_BIAS-1]  && !freeze;
    assign act_en     = (C > 0) && taps[T_ACT-1] && !freeze;
    assign quant_en   = taps[T_QUANT-1] && !freeze;
    assign buffer_en  = taps[T_BUF-1]   && !freeze;
    assign busy       = (state != IDLE) || (|taps);

    // valid is a single-beat handshake; a new completion takes priority over
    // the clear so a back-to-back result is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias_addr  <= '0;
            buffer_idx <= '0;
            valid      <= 1'b0;
        end else begin
            if (bias_en)
                bias_addr <= (bias_addr == BW'(pBIAS_NUM - 1)) ? '0 : bias_addr + 1'b1;
            if (buffer_en)
                buffer_idx <= (buffer_idx == OW'(OG - 1)) ? '0 : buffer_idx + 1'b1;
            if (buffer_en && (buffer_idx == OW'(OG - 1)))
                valid <= 1'b1;
            else if (out_ready)
                valid <= 1'b0;
        end
    end

`ifdef PE_CONV_MAC_SCHED_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_bp_cnt    <= '0;
        end else begin
            if (issue_fire && (perf_issue_cnt != '1)) perf_issue_cnt <= perf_issue_cnt + 1'b1;
            if (stall && (perf_stall_cnt != '1))      perf_stall_cnt <= perf_stall_cnt + 1'b1;
            if (valid && !out_ready && (perf_bp_cnt != '1)) perf_bp_cnt <= perf_bp_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_conv_mac_sched.sv
// Self-checking bench for pe_conv_mac_sched: a relu instance and an
// activation-free instance share stimulus; event cycles are scoreboarded.
module tb_pe_conv_mac_sched;

    logic clk = 1'b0;
    logic rst, win_valid, stall, out_ready;

    logic       win_ready, acc_clr, adder_en, dequant_en, bias_en, act_en, quant_en, buffer_en, valid, busy;
    logic [3:0] pixel;
    logic [1:0] ic_group, oc_group, buffer_idx;
    logic [5:0] kernel_addr;
    logic [4:0] bias_addr;

    logic       n_win_ready, n_acc_clr, n_adder_en, n_dequant_en, n_bias_en, n_act_en, n_quant_en, n_buffer_en, n_valid, n_busy;
    logic [3:0] n_pixel;
    logic [1:0] n_ic_group, n_oc_group, n_buffer_idx;
    logic [5:0] n_kernel_addr;
    logic [4:0] n_bias_addr;

`ifdef PE_CONV_MAC_SCHED_PERF_EN
    logic [31:0] perf_issue_cnt, perf_stall_cnt, perf_bp_cnt;
    logic [31:0] n_perf_issue_cnt, n_perf_stall_cnt, n_perf_bp_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en   = 1'b0;
    bit n_mon_en = 1'b0;

    int clr_q[$];
    int buf_q[$];
    int act_q[$];
    int valid_q[$];
    int n_buf_q[$];
    int n_valid_q[$];

    pe_conv_mac_sched #(
        .pIN_CHANNEL(4), .pINPUT_PARALLEL(2), .pOUT_CHANNEL(4), .pOUTPUT_PARALLEL(2),
        .pKERNEL_SIZE(3), .pMAC_STAGES(7), .pACTIVATION("relu"), .pBIAS_NUM(32)
    ) dut (
        .clk(clk), .rst(rst), .win_valid(win_valid), .win_ready(win_ready),
        .stall(stall), .out_ready(out_ready), .pixel(pixel), .ic_group(ic_group),
        .oc_group(oc_group), .kernel_addr(kernel_addr), .bias_addr(bias_addr),
        .acc_clr(acc_clr), .adder_en(adder_en), .dequant_en(dequant_en),
        .bias_en(bias_en), .act_en(act_en), .quant_en(quant_en), .buffer_en(buffer_en),
        .buffer_idx(buffer_idx), .valid(valid),
`ifdef PE_CONV_MAC_SCHED_PERF_EN
        .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt), .perf_bp_cnt(perf_bp_cnt),
`endif
        .busy(busy)
    );

    pe_conv_mac_sched #(
        .pIN_CHANNEL(4), .pINPUT_PARALLEL(2), .pOUT_CHANNEL(4), .pOUTPUT_PARALLEL(2),
        .pKERNEL_SIZE(3), .pMAC_STAGES(7), .pACTIVATION("none"), .pBIAS_NUM(32)
    ) dut_none (
        .clk(clk), .rst(rst), .win_valid(win_valid), .win_ready(n_win_ready),
        .stall(stall), .out_ready(out_ready), .pixel(n_pixel), .ic_group(n_ic_group),
        .oc_group(n_oc_group), .kernel_addr(n_kernel_addr), .bias_addr(n_bias_addr),
        .acc_clr(n_acc_clr), .adder_en(n_adder_en), .dequant_en(n_dequant_en),
        .bias_en(n_bias_en), .act_en(n_act_en), .quant_en(n_quant_en), .buffer_en(n_buffer_en),
        .buffer_idx(n_buffer_idx), .valid(n_valid),
`ifdef PE_CONV_MAC_SCHED_PERF_EN
        .perf_issue_cnt(n_perf_issue_cnt), .perf_stall_cnt(n_perf_stall_cnt), .perf_bp_cnt(n_perf_bp_cnt),
`endif
        .busy(n_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every event pulse pops the expected cycle it should occur on.
    always @(negedge clk) begin
        int e;
        if (mon_en) begin
            if (acc_clr) begin
                total++;
                if (clr_q.size() == 0) begin bad++; $display("FAIL acc_clr: pulse at cycle %0d, none expected", cyc); end
                else begin e = clr_q.pop_front(); if (cyc != e) begin bad++; $display("FAIL acc_clr: pulse at cycle %0d, expected %0d", cyc, e); end end
            end
            if (buffer_en) begin
                total++;
                if (buf_q.size() == 0) begin bad++; $display("FAIL buffer_en: pulse at cycle %0d, none expected", cyc); end
                else begin e = buf_q.pop_front(); if (cyc != e) begin bad++; $display("FAIL buffer_en: pulse at cycle %0d, expected %0d", cyc, e); end end
            end
            if (act_en) begin
                total++;
                if (act_q.size() == 0) begin bad++; $display("FAIL act_en: pulse at cycle %0d, none expected", cyc); end
                else begin e = act_q.pop_front(); if (cyc != e) begin bad++; $display("FAIL act_en: pulse at cycle %0d, expected %0d", cyc, e); end end
            end
            if (valid) begin
                total++;
                if (valid_q.size() == 0) begin bad++; $display("FAIL valid: high at cycle %0d, none expected", cyc); end
                else begin e = valid_q.pop_front(); if (cyc != e) begin bad++; $display("FAIL valid: high at cycle %0d, expected %0d", cyc, e); end end
            end
        end
        if (n_mon_en) begin
            total++;
            if (n_act_en !== 1'b0) begin bad++; $display("FAIL none_act_en: got %b at cycle %0d, want 0", n_act_en, cyc); end
            if (n_buffer_en) begin
                total++;
                if (n_buf_q.size() == 0) begin bad++; $display("FAIL none_buffer_en: pulse at cycle %0d, none expected", cyc); end
                else begin e = n_buf_q.pop_front(); if (cyc != e) begin bad++; $display("FAIL none_buffer_en: pulse at cycle %0d, expected %0d", cyc, e); end end
            end
            if (n_valid) begin
                total++;
                if (n_valid_q.size() == 0) begin bad++; $display("FAIL none_valid: high at cycle %0d, none expected", cyc); end
                else begin e = n_valid_q.pop_front(); if (cyc != e) begin bad++; $display("FAIL none_valid: high at cycle %0d, expected %0d", cyc, e); end end
            end
        end
    end

    task automatic goto_cycle(input int n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic apply_reset();
        mon_en = 1'b0; n_mon_en = 1'b0;
        rst = 1'b1; win_valid = 1'b0; stall = 1'b0; out_ready = 1'b1;
        clr_q.delete(); buf_q.delete(); act_q.delete(); valid_q.delete();
        n_buf_q.delete(); n_valid_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; win_valid = 1'b0; stall = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        total++; if (win_ready !== 1'b1) begin bad++; $display("FAIL reset_win_ready: got %b want 1", win_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        total++; if (kernel_addr !== 6'd0) begin bad++; $display("FAIL reset_kernel_addr: got %0d want 0", kernel_addr); end
        total++; if ({pixel, ic_group, oc_group, bias_addr, buffer_idx} !== 15'd0) begin bad++; $display("FAIL reset_counters: got %h want 0", {pixel, ic_group, oc_group, bias_addr, buffer_idx}); end
        total++; if ({acc_clr, adder_en, dequant_en, bias_en, act_en, quant_en, buffer_en} !== 7'd0) begin bad++; $display("FAIL reset_enables: got %b want 0", {acc_clr, adder_en, dequant_en, bias_en, act_en, quant_en, buffer_en}); end
    endtask

    task automatic test_single_window();
        int b;
        apply_reset();
        mon_en = 1'b1; n_mon_en = 1'b1;
        win_valid = 1'b1; b = cyc;
        clr_q = '{b + 1, b + 19}; buf_q = '{b + 31, b + 49}; act_q = '{b + 29, b + 47}; valid_q = '{b + 50};
        n_buf_q = '{b + 30, b + 48}; n_valid_q = '{b + 49};
        @(posedge clk); #1 win_valid = 1'b0;
        goto_cycle(b + 1);
        total++; if ({pixel, kernel_addr} !== 10'd0) begin bad++; $display("FAIL single_first_issue: pixel=%0d addr=%0d want 0/0", pixel, kernel_addr); end
        goto_cycle(b + 36);
        total++; if (kernel_addr !== 6'd35) begin bad++; $display("FAIL single_last_addr: got %0d want 35", kernel_addr); end
        goto_cycle(b + 37);
        total++; if (win_ready !== 1'b1 || kernel_addr !== 6'd0) begin bad++; $display("FAIL single_idle: ready=%b addr=%0d want 1/0", win_ready, kernel_addr); end
        goto_cycle(b + 55);
        total++; if (clr_q.size() + buf_q.size() + act_q.size() + valid_q.size() + n_buf_q.size() + n_valid_q.size() != 0)
            begin bad++; $display("FAIL single_pending: %0d events missing, want 0", clr_q.size() + buf_q.size() + act_q.size() + valid_q.size() + n_buf_q.size() + n_valid_q.size()); end
        total++; if (bias_addr !== 5'd2 || busy !== 1'b0) begin bad++; $display("FAIL single_final: bias_addr=%0d busy=%b want 2/0", bias_addr, busy); end
    endtask

    task automatic test_back_to_back();
        int b;
        apply_reset();
        mon_en = 1'b1;
        win_valid = 1'b1; b = cyc;
        clr_q = '{b + 1, b + 19, b + 37, b + 55}; buf_q = '{b + 31, b + 49, b + 67, b + 85};
        act_q = '{b + 29, b + 47, b + 65, b + 83}; valid_q = '{b + 50, b + 86};
        goto_cycle(b + 5);
        total++; if (win_ready !== 1'b0) begin bad++; $display("FAIL b2b_mid_ready: got %b want 0", win_ready); end
        goto_cycle(b + 36);
        total++; if (win_ready !== 1'b1 || kernel_addr !== 6'd35) begin bad++; $display("FAIL b2b_accept: ready=%b addr=%0d want 1/35", win_ready, kernel_addr); end
        @(posedge clk); #1 win_valid = 1'b0;
        goto_cycle(b + 37);
        total++; if (kernel_addr !== 6'd0 || pixel !== 4'd0) begin bad++; $display("FAIL b2b_wrap: addr=%0d pixel=%0d want 0/0", kernel_addr, pixel); end
        goto_cycle(b + 90);
        total++; if (clr_q.size() + buf_q.size() + act_q.size() + valid_q.size() != 0)
            begin bad++; $display("FAIL b2b_pending: %0d events missing, want 0", clr_q.size() + buf_q.size() + act_q.size() + valid_q.size()); end
    endtask

    task automatic test_stall();
        int b;
        apply_reset();
        mon_en = 1'b1;
        win_valid = 1'b1; b = cyc;
        clr_q = '{b + 1, b + 24}; buf_q = '{b + 36, b + 54}; act_q = '{b + 34, b + 52}; valid_q = '{b + 55};
        @(posedge clk); #1 win_valid = 1'b0;
        while (cyc < b + 10) begin @(posedge clk); #1; end
        stall = 1'b1;
        goto_cycle(b + 12);
        total++; if (kernel_addr !== 6'd9 || adder_en !== 1'b0) begin bad++; $display("FAIL stall_hold_a: addr=%0d want 9", kernel_addr); end
        while (cyc < b + 15) begin @(posedge clk); #1; end
        stall = 1'b0;
        goto_cycle(b + 16);
        total++; if (kernel_addr !== 6'd10) begin bad++; $display("FAIL stall_resume: addr=%0d want 10", kernel_addr); end
        goto_cycle(b + 60);
        total++; if (clr_q.size() + buf_q.size() + act_q.size() + valid_q.size() != 0)
            begin bad++; $display("FAIL stall_pending: %0d events missing, want 0", clr_q.size() + buf_q.size() + act_q.size() + valid_q.size()); end
    endtask

    task automatic test_stall_final();
        int b;
        apply_reset();
        win_valid = 1'b1; b = cyc;
        while (cyc < b + 36) begin @(posedge clk); #1; end
        stall = 1'b1;
        goto_cycle(b + 36);
        total++; if (win_ready !== 1'b0 || kernel_addr !== 6'd35) begin bad++; $display("FAIL stallfin_block: ready=%b addr=%0d want 0/35", win_ready, kernel_addr); end
        @(posedge clk); #1 stall = 1'b0;
        goto_cycle(b + 37);
        total++; if (win_ready !== 1'b1 || kernel_addr !== 6'd35) begin bad++; $display("FAIL stallfin_accept: ready=%b addr=%0d want 1/35", win_ready, kernel_addr); end
        @(posedge clk); #1 win_valid = 1'b0;
        goto_cycle(b + 38);
        total++; if (kernel_addr !== 6'd0 || acc_clr !== 1'b1) begin bad++; $display("FAIL stallfin_restart: addr=%0d clr=%b want 0/1", kernel_addr, acc_clr); end
    endtask

    task automatic test_backpressure();
        int b;
        apply_reset();
        mon_en = 1'b1;
        win_valid = 1'b1; b = cyc;
        clr_q = '{b + 1, b + 19, b + 37, b + 58}; buf_q = '{b + 31, b + 49, b + 70, b + 88};
        act_q = '{b + 29, b + 47, b + 68, b + 86}; valid_q = '{b + 50, b + 51, b + 52, b + 53, b + 89};
        while (cyc < b + 37) begin @(posedge clk); #1; end
        win_valid = 1'b0;
        while (cyc < b + 50) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        goto_cycle(b + 50);
        total++; if (kernel_addr !== 6'd13) begin bad++; $display("FAIL bp_freeze_a: addr=%0d want 13", kernel_addr); end
        goto_cycle(b + 52);
        total++; if (kernel_addr !== 6'd13 || valid !== 1'b1) begin bad++; $display("FAIL bp_freeze_b: addr=%0d valid=%b want 13/1", kernel_addr, valid); end
        @(posedge clk); #1 out_ready = 1'b1;
        goto_cycle(b + 54);
        total++; if (kernel_addr !== 6'd14 || valid !== 1'b0) begin bad++; $display("FAIL bp_release: addr=%0d valid=%b want 14/0", kernel_addr, valid); end
        goto_cycle(b + 95);
        total++; if (clr_q.size() + buf_q.size() + act_q.size() + valid_q.size() != 0)
            begin bad++; $display("FAIL bp_pending: %0d events missing, want 0", clr_q.size() + buf_q.size() + act_q.size() + valid_q.size()); end
    endtask

    task automatic test_reset_mid();
        int b;
        apply_reset();
        win_valid = 1'b1; b = cyc;
        @(posedge clk); #1 win_valid = 1'b0;
        goto_cycle(b + 20);
        total++; if (kernel_addr !== 6'd19) begin bad++; $display("FAIL rstmid_before: addr=%0d want 19", kernel_addr); end
        #2 rst = 1'b1;
        #1;
        total++; if (kernel_addr !== 6'd0 || busy !== 1'b0 || valid !== 1'b0 || win_ready !== 1'b1)
            begin bad++; $display("FAIL rstmid_async: addr=%0d busy=%b valid=%b ready=%b want 0/0/0/1", kernel_addr, busy, valid, win_ready); end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 win_valid = 1'b1; b = cyc;
        @(posedge clk); #1 win_valid = 1'b0;
        goto_cycle(b + 1);
        total++; if (pixel !== 4'd0 || kernel_addr !== 6'd0 || acc_clr !== 1'b1) begin bad++; $display("FAIL rstmid_restart: pixel=%0d addr=%0d clr=%b want 0/0/1", pixel, kernel_addr, acc_clr); end
        goto_cycle(b + 2);
        total++; if (kernel_addr !== 6'd1) begin bad++; $display("FAIL rstmid_advance: addr=%0d want 1", kernel_addr); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_window();
        test_back_to_back();
        test_stall();
        test_stall_final();
        test_backpressure();
        test_reset_mid();
        $display("[TB] all scenarios complete");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
